bcd_entry_display: RTL and testbench

- Downstream consumer of the decimal-to-BCD encoder stage.
- Accepts one BCD digit per keypress strobe and shifts it into a NUM_DIGITS-digit entry register, most recent digit rightmost.
- Drives a time-multiplexed, active-low common-anode seven-segment display.
- Exposes the packed BCD value to downstream logic and flags invalid codes and entry overflow.

---
 rtl/bcd_disp_pkg.sv | 26 ++
 rtl/bcd_to_seven_seg.sv | 24 ++
 rtl/bcd_entry_display.sv | 137 +++++++++++++
 tb/tb_bcd_entry_display.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_disp_pkg.sv
// ============================================================================
// Module      : bcd_disp_pkg
// Description : Shared constants and helpers for the BCD entry display.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_disp_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_ZERO  = 7'h40;
    localparam logic [3:0] BCD_MAX   = 4'd9;

    // Active-low {g,f,e,d,c,b,a} patterns, element [n] lights digit n.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic is_bcd(input logic [3:0] d);
        return (d <= BCD_MAX);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_to_seven_seg.sv
// ============================================================================
// Module      : bcd_to_seven_seg
// Description : Combinational BCD to active-low seven-segment lookup.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_to_seven_seg
    import bcd_disp_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (is_bcd(digit_i)) begin
            seg_o = SEG_TABLE[digit_i];
        end
    end

endmodule

`default_nettype wire

// File: rtl/bcd_entry_display.sv
// ============================================================================
// Module      : bcd_entry_display
// Description : Keypad BCD entry register with multiplexed 7-segment scan.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_entry_display
    import bcd_disp_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [3:0]              bcd_in,
    input  logic                    bcd_valid,
    input  logic                    clear,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic [3:0]              digit_count,
    output logic                    overflow,
    output logic                    err,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int                   VAL_W        = 4 * NUM_DIGITS;
    localparam int                   CNT_W        = $clog2(REFRESH_DIV);
    localparam int                   IDX_W        = $clog2(NUM_DIGITS);
    localparam logic [3:0]           COUNT_MAX    = 4'(NUM_DIGITS);
    localparam logic [CNT_W-1:0]     REFRESH_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]     IDX_LAST     = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_ONE      = NUM_DIGITS'(1);

    logic                   valid_q;
    logic [VAL_W-1:0]       value_q,    value_d;
    logic [3:0]             count_q,    count_d;
    logic                   overflow_q, overflow_d;
    logic                   err_q,      err_d;
    logic [CNT_W-1:0]       refresh_q,  refresh_d;
    logic [IDX_W-1:0]       idx_q,      idx_d;
    logic [6:0]             seg_q,      seg_d;
    logic [NUM_DIGITS-1:0]  an_q,       an_d;

    logic                   w_strobe;
    logic [3:0]             w_digit;
    logic [6:0]             w_digit_seg;

    assign w_strobe = bcd_valid & ~valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            value_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            err_q      <= 1'b0;
            refresh_q  <= '0;
            idx_q      <= '0;
            seg_q      <= SEG_BLANK;
            an_q       <= '1;
        end else begin
            valid_q    <= bcd_valid;
            value_q    <= value_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            err_q      <= err_d;
            refresh_q  <= refresh_d;
            idx_q      <= idx_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
        end
    end

    // Clear takes priority: a colliding strobe is dropped and never flags err.
    always_comb begin
        value_d    = value_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        err_d      = 1'b0;
        if (clear) begin
            value_d    = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else if (w_strobe) begin
            if (is_bcd(bcd_in)) begin
                value_d = {value_q[VAL_W-5:0], bcd_in};
                if (count_q == COUNT_MAX) begin
                    overflow_d = 1'b1;
                end else begin
                    count_d = count_q + 4'd1;
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_comb begin
        refresh_d = refresh_q + CNT_W'(1);
        idx_d     = idx_q;
        if (refresh_q == REFRESH_LAST) begin
            refresh_d = '0;
            idx_d     = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
    end

    assign w_digit = value_q[{idx_q, 2'b00} +: 4];

    bcd_to_seven_seg u_seg_lut (
        .digit_i (w_digit),
        .seg_o   (w_digit_seg)
    );

    // Empty entry still shows a single '0' in the rightmost position.
    always_comb begin
        an_d  = ~(AN_ONE << idx_q);
        seg_d = SEG_BLANK;
        if (count_q == 4'd0) begin
            if (idx_q == '0) begin
                seg_d = SEG_ZERO;
            end
        end else if (4'(idx_q) < count_q) begin
            seg_d = w_digit_seg;
        end
    end

    assign value       = value_q;
    assign digit_count = count_q;
    assign overflow    = overflow_q;
    assign err         = err_q;
    assign seg         = seg_q;
    assign an          = an_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_entry_display.sv
// ============================================================================
// Module      : tb_bcd_entry_display
// Description : Scoreboard bench for bcd_entry_display (4 digits, divide by 4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_entry_display;

    localparam int ND = 4;
    localparam int RD = 4;

    typedef logic [20:0] tup_t;  // {value, digit_count, overflow}

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic [3:0]        bcd_in    = 4'd0;
    logic              bcd_valid = 1'b0;
    logic              clear     = 1'b0;
    logic [4*ND-1:0]   value;
    logic [3:0]        digit_count;
    logic              overflow;
    logic              err;
    logic [6:0]        seg;
    logic [ND-1:0]     an;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic started  = 1'b0;
    tup_t exp_q[$];
    tup_t err_exp_q[$];
    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    bcd_entry_display #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bcd_in      (bcd_in),
        .bcd_valid   (bcd_valid),
        .clear       (clear),
        .value       (value),
        .digit_count (digit_count),
        .overflow    (overflow),
        .err         (err),
        .seg         (seg),
        .an          (an)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every change of the entry outputs and every err pulse is scored.
    initial begin : monitor
        tup_t last;
        tup_t cur;
        logic prev_err;
        last     = '0;
        prev_err = 1'b0;
        wait (started);
        forever begin
            @(negedge clk);
            cur = {value, digit_count, overflow};
            if (cur !== last) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_update: got %0h expected no change from %0h", cur, last);
                end else begin
                    check("entry_update", cur, exp_q.pop_front());
                end
                last = cur;
            end
            if (err === 1'b1) begin
                if (prev_err) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL err_width: got err high 2+ cycles expected 1");
                end else if (err_exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_err: got err=1 expected 0");
                end else begin
                    check("err_snapshot", cur, err_exp_q.pop_front());
                end
            end
            prev_err = (err === 1'b1);
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic press(input logic [3:0] d, input int hold, input tup_t exp);
        exp_q.push_back(exp);
        @(posedge clk); #2;
        bcd_in    = d;
        bcd_valid = 1'b1;
        repeat (hold) @(posedge clk);
        #2 bcd_valid = 1'b0;
        @(posedge clk); #2;
    endtask

    task automatic press_bad(input logic [3:0] d, input int hold, input tup_t snap);
        err_exp_q.push_back(snap);
        @(posedge clk); #2;
        bcd_in    = d;
        bcd_valid = 1'b1;
        repeat (hold) @(posedge clk);
        #2 bcd_valid = 1'b0;
        @(posedge clk); #2;
    endtask

    task automatic check_display(input logic [15:0] v, input int cnt, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            int         idx;
            logic [6:0] exp_seg;
            @(negedge clk);
            idx = -1;
            for (int j = 0; j < ND; j++) begin
                if (an === ~(4'b0001 << j)) idx = j;
            end
            check("an_onehot_low", 32'(idx >= 0), 32'd1);
            if (idx >= 0) begin
                if (cnt == 0)        exp_seg = (idx == 0) ? 7'h40 : 7'h7F;
                else if (idx < cnt)  exp_seg = seg_tab[v[idx*4 +: 4]];
                else                 exp_seg = 7'h7F;
                check("seg_digit", seg, exp_seg);
            end
        end
    endtask

    initial begin : stimulus
        logic [3:0] exp_an;
        int         waited;
        logic       found;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_value", value, 0);
        check("rst_count", digit_count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_err", err, 0);
        check("rst_seg", seg, 7'h7F);
        check("rst_an", an, 4'hF);
        rst_n   = 1'b1;
        started = 1'b1;

        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            exp_an = ~(4'b0001 << (((k - 1) / RD) % ND));
            check("idle_an", an, exp_an);
            check("idle_seg", seg, (exp_an == 4'hE) ? 7'h40 : 7'h7F);
        end
        check("idle_value", value, 0);
        check("idle_count", digit_count, 0);

        press(4'd3, 10, {16'h0003, 4'd1, 1'b0});
        press(4'd7, 10, {16'h0037, 4'd2, 1'b0});
        check("entry_value", value, 16'h0037);
        check("entry_count", digit_count, 2);
        check_display(16'h0037, 2, 16);

        exp_q.push_back('0);
        @(posedge clk); #2 clear = 1'b1;
        @(posedge clk); #2 clear = 1'b0;

        press(4'd1, 3, {16'h0001, 4'd1, 1'b0});
        press(4'd2, 3, {16'h0012, 4'd2, 1'b0});
        press(4'd3, 3, {16'h0123, 4'd3, 1'b0});
        press(4'd4, 3, {16'h1234, 4'd4, 1'b0});
        press(4'd5, 3, {16'h2345, 4'd4, 1'b1});
        repeat (20) @(negedge clk);
        check("ovf_sticky", overflow, 1);
        check("ovf_value", value, 16'h2345);
        check("ovf_count", digit_count, 4);
        check_display(16'h2345, 4, 16);

        press_bad(4'hC, 5, {16'h2345, 4'd4, 1'b1});
        repeat (4) @(negedge clk);
        check("bad_value", value, 16'h2345);
        check("bad_count", digit_count, 4);
        check("bad_overflow", overflow, 1);

        exp_q.push_back('0);
        @(posedge clk); #2;
        clear = 1'b1; bcd_in = 4'd8; bcd_valid = 1'b1;
        @(posedge clk); #2 clear = 1'b0;
        repeat (8) @(posedge clk);
        #2 bcd_valid = 1'b0;
        @(negedge clk);
        check("coll_value", value, 0);
        check("coll_count", digit_count, 0);
        check("coll_overflow", overflow, 0);

        @(posedge clk); #2;
        clear = 1'b1; bcd_in = 4'hC; bcd_valid = 1'b1;
        @(posedge clk); #2 clear = 1'b0;
        repeat (3) @(posedge clk);
        #2 bcd_valid = 1'b0;

        press(4'd6, 2, {16'h0006, 4'd1, 1'b0});
        press(4'd9, 2, {16'h0069, 4'd2, 1'b0});

        waited = 0;
        found  = 1'b0;
        while (!found && waited < 64) begin
            @(negedge clk);
            if (an === 4'hB) found = 1'b1;
            waited++;
        end
        check("wait_an_B", 32'(found), 32'd1);
        if (found) begin
            exp_q.push_back('0);
            #2 rst_n = 1'b0;
            #1;
            check("async_an", an, 4'hF);
            check("async_seg", seg, 7'h7F);
            check("async_value", value, 0);
            check("async_count", digit_count, 0);
            @(negedge clk);
            rst_n = 1'b1;
            repeat (4) @(negedge clk);
            check("post_rst_value", value, 0);
        end

        repeat (3) @(negedge clk);
        check("pending_updates", exp_q.size(), 0);
        check("pending_errs", err_exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
